// File: rtl/processador_nbits.sv
// processador_nbits
// -----------------------------------------------------------------------------
// Multicycle accumulator processor with configurable data/address width.
// Every instruction is two words: an opcode word (opcode in bits [3:0]) and an
// operand word. Memory ops (LDA/STA/ADD/SUB/AND/OR/XOR) need a third access.
//
// Memory handshake: an access is open while mem_req=1. address, mem_we and
// to_memory stay constant until the rising edge that samples mem_req=1 and
// mem_ready=1; that edge completes the access. Read data on from_memory is
// taken on that same edge. mem_ready is don't-care while mem_req=0, and a new
// access may start right after the completing edge (back-to-back).
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   from_memory  read data, valid on the completing edge
//   to_memory    write data (A during an STA access, 0 otherwise)
//   address      memory address
//   mem_req      access request
//   mem_we       1 = write, 0 = read (valid with mem_req)
//   mem_ready    access completion from memory
//   acc          accumulator A
//   done         high once HLT (or a trapped opcode) has executed
//   illegal      only with PROC_ILLEGAL_TRAP_EN: sticky illegal-opcode flag
//   dbg_state    current FSM state (FETCH_OP=0, FETCH_ARG=1, EXEC_MEM=2, HALT=3)
//
// Optional feature macro: PROC_ILLEGAL_TRAP_EN. When defined, opcodes C/D/E
// halt the core and raise illegal; otherwise they behave as NOP.
// -----------------------------------------------------------------------------
module processador_nbits #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] from_memory,
    output logic [DATA_W-1:0] to_memory,
    output logic [ADDR_W-1:0] address,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc,
    output logic              done,
`ifdef PROC_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        EXEC_MEM  = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [3:0]        opc_q, opc_d;
    logic [ADDR_W-1:0] arg_q, arg_d;
`ifdef PROC_ILLEGAL_TRAP_EN
    logic              ill_q, ill_d;
`endif

    // Operand word viewed as an address: truncated or zero-extended to ADDR_W.
    logic [ADDR_W-1:0] word_addr;
    generate
        if (ADDR_W <= DATA_W) begin : g_addr_trunc
            assign word_addr = from_memory[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign word_addr = {{(ADDR_W-DATA_W){1'b0}}, from_memory};
        end
    endgenerate

    // MSB of the extended sum is the carry; MSB of the extended difference is
    // the borrow (set exactly when A < M).
    logic [DATA_W:0] sum, diff;
    assign sum  = {1'b0, a_q} + {1'b0, from_memory};
    assign diff = {1'b0, a_q} - {1'b0, from_memory};

    logic [ADDR_W-1:0] pc_inc;
    assign pc_inc = pc_q + ADDR_W'(1);

    logic [DATA_W-1:0] alu_res;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        z_d     = z_q;
        c_d     = c_q;
        opc_d   = opc_q;
        arg_d   = arg_q;
        alu_res = a_q;
`ifdef PROC_ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            FETCH_OP: begin
                if (mem_ready) begin
                    opc_d   = from_memory[3:0];
                    pc_d    = pc_inc;
                    state_d = FETCH_ARG;
                end
            end
            FETCH_ARG: begin
                if (mem_ready) begin
                    arg_d   = word_addr;
                    pc_d    = pc_inc;
                    state_d = FETCH_OP;
                    case (opc_q)
                        OP_LDI: begin
                            a_d = from_memory;
                            z_d = (from_memory == '0);
                        end
                        OP_JMP: pc_d = word_addr;
                        OP_JZ:  if (z_q) pc_d = word_addr;
                        OP_JC:  if (c_q) pc_d = word_addr;
                        OP_HLT: state_d = HALT;
                        OP_LDA, OP_STA, OP_ADD, OP_SUB,
                        OP_AND, OP_OR, OP_XOR: state_d = EXEC_MEM;
`ifdef PROC_ILLEGAL_TRAP_EN
                        4'hC, 4'hD, 4'hE: begin
                            state_d = HALT;
                            ill_d   = 1'b1;
                        end
`endif
                        default: ; // NOP (and undefined opcodes without the trap)
                    endcase
                end
            end
            EXEC_MEM: begin
                if (mem_ready) begin
                    state_d = FETCH_OP;
                    case (opc_q)
                        OP_LDA: alu_res = from_memory;
                        OP_ADD: begin
                            alu_res = sum[DATA_W-1:0];
                            c_d     = sum[DATA_W];
                        end
                        OP_SUB: begin
                            alu_res = diff[DATA_W-1:0];
                            c_d     = diff[DATA_W];
                        end
                        OP_AND: alu_res = a_q & from_memory;
                        OP_OR:  alu_res = a_q | from_memory;
                        OP_XOR: alu_res = a_q ^ from_memory;
                        default: alu_res = a_q;
                    endcase
                    // STA only completes the write; everything else here loads A.
                    if (opc_q != OP_STA) begin
                        a_d = alu_res;
                        z_d = (alu_res == '0);
                    end
                end
            end
            HALT: ;
            default: state_d = FETCH_OP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH_OP;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            opc_q   <= '0;
            arg_q   <= '0;
`ifdef PROC_ILLEGAL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            z_q     <= z_d;
            c_q     <= c_d;
            opc_q   <= opc_d;
            arg_q   <= arg_d;
`ifdef PROC_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    // Bus outputs are gated by reset so an access in flight is dropped the
    // moment reset asserts, without waiting for a clock edge.
    assign mem_req   = reset && (state_q != HALT);
    assign mem_we    = reset && (state_q == EXEC_MEM) && (opc_q == OP_STA);
    assign address   = !reset ? '0 : ((state_q == EXEC_MEM) ? arg_q : pc_q);
    assign to_memory = mem_we ? a_q : '0;
    assign acc       = a_q;
    assign done      = (state_q == HALT);
    assign dbg_state = state_q;
`ifdef PROC_ILLEGAL_TRAP_EN
    assign illegal   = ill_q;
`endif

endmodule

// File: tb/tb_processador_nbits.sv
// Testbench for processador_nbits: ISA-level reference model feeding an
// expected-transaction queue, a bus monitor that pops and compares every
// completed access, plus end-of-program checks.
module tb_processador_nbits;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic w_reset = 1'b0;
    always #5 clock = ~clock;

    // ---------------- main DUT (8/8) ----------------
    logic [7:0] mem [256];
    logic [7:0] from_memory, to_memory, address, acc;
    logic       mem_req, mem_we, mem_ready, done;
    logic [1:0] dbg_state;
`ifdef PROC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
    assign from_memory = mem[address];

    processador_nbits #(.DATA_W(8), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .from_memory(from_memory),
        .to_memory(to_memory), .address(address), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ready(mem_ready), .acc(acc), .done(done),
`ifdef PROC_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- wrap DUT (ADDR_W=4, RESET_PC=E) ----------------
    logic [7:0] w_mem [16];
    logic [7:0] w_from, w_to, w_acc;
    logic [3:0] w_addr;
    logic       w_req, w_we, w_done;
    logic       w_ready = 1'b1;
    logic [1:0] w_dbg_state;
`ifdef PROC_ILLEGAL_TRAP_EN
    logic       w_illegal;
`endif
    assign w_from = w_mem[w_addr];

    processador_nbits #(.DATA_W(8), .ADDR_W(4), .RESET_PC(4'hE)) dut_w (
        .clock(clock), .reset(w_reset), .from_memory(w_from),
        .to_memory(w_to), .address(w_addr), .mem_req(w_req),
        .mem_we(w_we), .mem_ready(w_ready), .acc(w_acc), .done(w_done),
`ifdef PROC_ILLEGAL_TRAP_EN
        .illegal(w_illegal),
`endif
        .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    // Entry = {we, address, write data (0 for reads)}
    logic [16:0] exp_q[$];
    logic [16:0] exp_w_q[$];
    logic [7:0]  ref_mem [256];
    int total = 0;
    int bad   = 0;
    int wait_min = 0;
    int wait_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (ISA level) ----------------
    task automatic push_exp(input bit to_w, input logic [16:0] e);
        if (to_w) exp_w_q.push_back(e);
        else      exp_q.push_back(e);
    endtask

    task automatic model_run(input logic [7:0] mask, input logic [7:0] rpc, input bit to_w,
                             output logic [7:0] fa, output int cyc, output bit ill);
        logic [7:0] pc, a, arg, m, ea;
        logic [3:0] opc;
        logic [8:0] s;
        logic z, c;
        pc = rpc; a = 8'h00; z = 1'b0; c = 1'b0; cyc = 0; ill = 1'b0;
        for (int step = 0; step < 500; step++) begin
            push_exp(to_w, {1'b0, pc, 8'h00});
            m = ref_mem[pc];
            opc = m[3:0];
            pc = (pc + 8'd1) & mask;
            push_exp(to_w, {1'b0, pc, 8'h00});
            arg = ref_mem[pc];
            pc = (pc + 8'd1) & mask;
            cyc += 2;
            ea = arg & mask;
            if (opc == 4'hF) break;
`ifdef PROC_ILLEGAL_TRAP_EN
            if (opc >= 4'hC && opc <= 4'hE) begin
                ill = 1'b1;
                break;
            end
`endif
            if (opc >= 4'h2 && opc <= 4'h8) begin
                cyc += 1;
                m = ref_mem[ea];
                if (opc == 4'h3) begin
                    push_exp(to_w, {1'b1, ea, a});
                    ref_mem[ea] = a;
                end else begin
                    push_exp(to_w, {1'b0, ea, 8'h00});
                    case (opc)
                        4'h2: a = m;
                        4'h4: begin s = {1'b0, a} + {1'b0, m}; c = s[8]; a = s[7:0]; end
                        4'h5: begin c = (a < m); a = a - m; end
                        4'h6: a = a & m;
                        4'h7: a = a | m;
                        default: a = a ^ m;
                    endcase
                    z = (a == 8'h00);
                end
            end else begin
                case (opc)
                    4'h1: begin a = arg; z = (a == 8'h00); end
                    4'h9: pc = ea;
                    4'hA: if (z) pc = ea;
                    4'hB: if (c) pc = ea;
                    default: ;
                endcase
            end
        end
        fa = a;
    endtask

    // ---------------- memory ready driver ----------------
    initial begin
        int pend = 0;
        int tgt  = 0;
        mem_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (wait_max == 0) begin
                mem_ready = 1'b1;
            end else if (!reset || !mem_req) begin
                mem_ready = 1'b0;
                pend = 0;
                tgt = $urandom_range(wait_max, wait_min);
            end else begin
                if (mem_ready) begin
                    pend = 0;
                    tgt = $urandom_range(wait_max, wait_min);
                end
                mem_ready = (pend >= tgt);
                pend++;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic        pend_mon = 1'b0;
        logic [16:0] held = '0;
        logic [16:0] act, e;
        forever begin
            @(negedge clock);
            #1;
            if (reset && mem_req) begin
                act = {mem_we, address, to_memory};
                if (pend_mon) check("bus_hold", act, held);
                if (mem_ready) begin
                    pend_mon = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("bus_unexpected", act, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("bus_access", act, e);
                    end
                    if (mem_we) mem[address] = to_memory;
                end else begin
                    if (!pend_mon) held = act;
                    pend_mon = 1'b1;
                end
            end else begin
                pend_mon = 1'b0;
            end
        end
    end

    initial begin
        logic [16:0] act, e;
        forever begin
            @(negedge clock);
            #1;
            if (w_reset && w_req && w_ready) begin
                act = {w_we, 4'h0, w_addr, w_to};
                if (exp_w_q.size() == 0) begin
                    check("wrap_unexpected", act, 32'hFFFF_FFFF);
                end else begin
                    e = exp_w_q.pop_front();
                    check("wrap_access", act, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h05;   // LDI 05
        mem[2] = 8'h03; mem[3] = 8'h80;   // STA 80
        mem[4] = 8'h04; mem[5] = 8'h80;   // ADD 80
        mem[6] = 8'h0F; mem[7] = 8'h00;   // HLT
    endtask

    task automatic start_prog(input int wmin, input int wmax,
                              output logic [7:0] e_acc, output int e_cyc, output bit e_ill);
        reset = 1'b0;
        wait_min = wmin;
        wait_max = wmax;
        repeat (2) @(posedge clock);
        exp_q.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        model_run(8'hFF, 8'h00, 1'b0, e_acc, e_cyc, e_ill);
        @(posedge clock);
        #2 reset = 1'b1;
    endtask

    task automatic finish_prog(input string tag, input logic [7:0] e_acc, input int e_cyc,
                               input bit chk_cyc, input bit e_ill, output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            #2;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, {31'd0, got}, 32'd1);
        check({tag, "_acc"}, {24'd0, acc}, {24'd0, e_acc});
        if (chk_cyc) check({tag, "_cycles"}, cyc, e_cyc);
        check({tag, "_queue_left"}, exp_q.size(), 0);
`ifdef PROC_ILLEGAL_TRAP_EN
        check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, e_ill});
`else
        if (e_ill) check({tag, "_model_ill"}, 32'd1, 32'd0);
`endif
        repeat (3) @(negedge clock);
        #2;
        check({tag, "_req_low_after"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] e_acc;
        int e_cyc, cyc;
        bit e_ill, seen;
        logic [3:0] opc;

        // Reset state
        clear_mem();
        repeat (2) @(posedge clock);
        @(negedge clock); #2;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, address}, 32'd0);
        check("rst_wdata", {24'd0, to_memory}, 32'd0);
        check("rst_acc", {24'd0, acc}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Basic, zero wait
        load_basic();
        start_prog(0, 0, e_acc, e_cyc, e_ill);
        #1 check("basic_first_req", {31'd0, mem_req}, 32'd1);
        finish_prog("basic", e_acc, e_cyc, 1'b1, e_ill, cyc);
        check("basic_acc_0A", {24'd0, acc}, 32'h0A);
        check("basic_m80", {24'd0, mem[8'h80]}, 32'h05);
        check("basic_10_cycles", cyc, 10);

        // Carry / branch
        clear_mem();
        mem[8'h00] = 8'h01; mem[8'h01] = 8'hFF;   // LDI FF
        mem[8'h02] = 8'h03; mem[8'h03] = 8'h80;   // STA 80
        mem[8'h04] = 8'h01; mem[8'h05] = 8'h01;   // LDI 01
        mem[8'h06] = 8'h04; mem[8'h07] = 8'h80;   // ADD 80 -> carry
        mem[8'h08] = 8'h0B; mem[8'h09] = 8'h20;   // JC 20
        mem[8'h0A] = 8'h0F; mem[8'h0B] = 8'h00;   // HLT (skipped)
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h77;   // LDI 77
        mem[8'h22] = 8'h0F; mem[8'h23] = 8'h00;   // HLT
        start_prog(0, 0, e_acc, e_cyc, e_ill);
        finish_prog("branch", e_acc, e_cyc, 1'b1, e_ill, cyc);
        check("branch_acc_77", {24'd0, acc}, 32'h77);

        // Wait states: 3 cycles per access
        load_basic();
        start_prog(3, 3, e_acc, e_cyc, e_ill);
        finish_prog("wait3", e_acc, e_cyc, 1'b0, e_ill, cyc);
        check("wait3_acc_0A", {24'd0, acc}, 32'h0A);
        check("wait3_m80", {24'd0, mem[8'h80]}, 32'h05);

        // Reset while STA is stalled
        load_basic();
        mem[8'h80] = 8'h5A;
        start_prog(5, 5, e_acc, e_cyc, e_ill);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #2;
            if (mem_req && mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        check("rstmid_sta_seen", {31'd0, seen}, 32'd1);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        check("rstmid_req_async", {31'd0, mem_req}, 32'd0);
        check("rstmid_we", {31'd0, mem_we}, 32'd0);
        check("rstmid_acc", {24'd0, acc}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clock);
        check("rstmid_no_write", {24'd0, mem[8'h80]}, 32'h5A);
        exp_q.delete();
        start_prog(0, 0, e_acc, e_cyc, e_ill);
        finish_prog("rstmid_rerun", e_acc, e_cyc, 1'b1, e_ill, cyc);
        check("rstmid_rerun_acc", {24'd0, acc}, 32'h0A);

        // Undefined opcode 0xC at address 0
        clear_mem();
        mem[0] = 8'h0C; mem[1] = 8'h00;
        mem[2] = 8'h0F; mem[3] = 8'h00;
        start_prog(0, 0, e_acc, e_cyc, e_ill);
        finish_prog("illop", e_acc, e_cyc, 1'b1, e_ill, cyc);
`ifdef PROC_ILLEGAL_TRAP_EN
        check("illop_2_cycles", cyc, 2);
        check("illop_flag", {31'd0, illegal}, 32'd1);
`else
        check("illop_nop_4_cycles", cyc, 4);
`endif

        // Random programs: forward-only branches, HLT at 3E, data in 80..FF
        for (int r = 0; r < 5; r++) begin
            clear_mem();
            for (int p = 0; p < 62; p += 2) begin
                opc = 4'($urandom_range(0, 15));
                if (opc == 4'hF && $urandom_range(0, 3) != 0) opc = 4'h0;
                mem[p] = (8'($urandom_range(0, 255)) & 8'hF0) | {4'h0, opc};
                if (opc >= 4'h2 && opc <= 4'h8)
                    mem[p+1] = 8'h80 | 8'($urandom_range(0, 127));
                else if (opc >= 4'h9 && opc <= 4'hB)
                    mem[p+1] = 8'(p + 2 + 2 * $urandom_range(0, (62 - p - 2) / 2));
                else
                    mem[p+1] = 8'($urandom_range(0, 255));
            end
            mem[62] = 8'h0F; mem[63] = 8'h00;
            for (int i = 128; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
            start_prog(0, (r == 0) ? 0 : 3, e_acc, e_cyc, e_ill);
            finish_prog("random", e_acc, e_cyc, (r == 0), e_ill, cyc);
            for (int i = 128; i < 256; i++)
                if (mem[i] !== ref_mem[i]) check("random_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});
        end

        // PC wrap with ADDR_W=4, RESET_PC=E
        w_reset = 1'b0;
        for (int i = 0; i < 16; i++) w_mem[i] = 8'h00;
        w_mem[0] = 8'h0F;
        for (int i = 0; i < 256; i++) ref_mem[i] = (i < 16) ? w_mem[i] : 8'h00;
        exp_w_q.delete();
        model_run(8'h0F, 8'h0E, 1'b1, e_acc, e_cyc, e_ill);
        @(posedge clock);
        #2 w_reset = 1'b1;
        cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock);
            cyc++;
            @(negedge clock); #2;
            if (w_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("wrap_done", {31'd0, seen}, 32'd1);
        check("wrap_4_cycles", cyc, 4);
        check("wrap_model_cycles", cyc, e_cyc);
        check("wrap_queue_left", exp_w_q.size(), 0);
        check("wrap_acc", {24'd0, w_acc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processador_nbits.md
Name: processador_nbits

Overview:
Parametrised successor of the 8-bit core: a multicycle accumulator processor with configurable data and address width.
- Memory access goes through a req/ready handshake that tolerates wait states.
- Supports conditional branches on zero and carry flags.
- Halts with a sticky done flag.
- Sits between the top-level bench/SoC and a single shared instruction/data memory.

Parameters:
DATA_W, 8, width of accumulator, memory words and ALU (4..32)
ADDR_W, 8, width of PC and address bus; operands are truncated/zero-extended to ADDR_W
RESET_PC, 0, PC value loaded on reset (ADDR_W bits)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
from_memory  input  DATA_W  read data, valid on the edge where mem_ready=1
to_memory  output  DATA_W  write data; equals A during an STA request, 0 otherwise
address  output  ADDR_W  memory address, stable while mem_req=1
mem_req  output  1  access request
mem_we  output  1  1=write, 0=read; valid with mem_req
mem_ready  input  1  access completes on a rising edge with mem_req=1 and mem_ready=1
acc  output  DATA_W  current accumulator A
done  output  1  set on HLT, sticky until reset

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, A=0, Z=0, C=0, state=FETCH_OP. All outputs 0 (mem_req drops immediately, even mid-access).
- Instruction format: two words, each fetched via handshake.
  - Opcode word: opcode = bits[3:0], upper bits ignored.
  - Operand word: op.
- PC increments by 1 after each completed fetch word, modulo 2^ADDR_W (wraps max→0).
- Opcodes:
  - 0 NOP.
  - 1 LDI: A=op[DATA_W-1:0].
  - 2 LDA: A=M[op].
  - 3 STA: M[op]=A.
  - 4 ADD: A=A+M[op], C=carry out.
  - 5 SUB: A=A-M[op], C=borrow.
  - 6 AND, 7 OR, 8 XOR: A op M[op].
  - 9 JMP: PC=op.
  - A JZ: if Z then PC=op.
  - B JC: if C then PC=op.
  - F HLT.
  - C/D/E are undefined (see Optional Feature).
- Flags: Z updated by LDI/LDA/ADD/SUB/AND/OR/XOR (Z = A_new==0). C updated only by ADD/SUB. All other instructions leave flags unchanged.
- States:
  - FETCH_OP: address=PC, req=1, we=0. On ready: latch opcode, PC+1, go to FETCH_ARG.
  - FETCH_ARG: on ready: latch op, PC+1. Then:
    - NOP/LDI/JMP/JZ/JC → execute this edge, go to FETCH_OP.
    - HLT → HALT.
    - memory ops → EXEC_MEM.
  - EXEC_MEM: address=op. STA: we=1, to_memory=A. Others: we=0. On ready: update A/flags or complete the write, go to FETCH_OP.
  - HALT: req=0, done=1. Stays here until reset; mem_ready is ignored.
- Handshake:
  - address, mem_we and to_memory are held constant from req rise until the completing edge.
  - mem_req falls for at least 0 cycles between accesses (back-to-back allowed).
  - mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory (ready tied 1): 2 cycles for LDI/JMP/Jcc/NOP/HLT, 3 cycles for memory ops. Each wait cycle adds 1.
- Branch target is written to PC on the FETCH_ARG edge. The next FETCH_OP uses the new PC.
- Reset released: first request is asserted in the first cycle after reset=1.

Optional Feature:
Macro PROC_ILLEGAL_TRAP_EN.
- Defined: extra output illegal (1 bit, reset 0). Opcodes C/D/E, on the FETCH_ARG completion edge, go to HALT with done=1 and illegal=1 (sticky until reset).
- Undefined: port absent; C/D/E execute as NOP (2 cycles, no state change except PC).

Test Plan:
- Basic, ready tied 1, DATA_W=8, ADDR_W=8. Program LDI 05; STA 80; ADD 80; HLT → M[80]=05, acc=0A, done=1 after 2+3+3+2=10 cycles, mem_req=0 thereafter.
- Carry/branch. Program LDI FF; STA 80; LDI 01; ADD 80; JC 20; HLT@0A; LDI 77@20; HLT → acc=77, done=1. The fall-through HLT at 0A is never fetched.
- Wait states: mem_ready asserted 3 cycles after each req rise → same final memory/acc as the Basic test. address, mem_we and to_memory are checked constant throughout every wait.
- Reset mid-operation: pulse reset=0 while EXEC_MEM STA is stalled (ready=0) → mem_req falls asynchronously, no write occurs, acc=0, done=0. After release, first fetch is at address 00.
- Wrap: ADDR_W=4, RESET_PC=E, M[E]=0 (NOP), M[F]=0, M[0]=F (HLT) → fetch addresses E,F,0,1, then done=1.
- Illegal: opcode 0xC at address 0.
  - With PROC_ILLEGAL_TRAP_EN: done=1 and illegal=1 after 2 cycles.
  - Without: executes as NOP and fetch continues at 02.
